// File: rtl/ctrl_axil_pkg.sv
// ctrl_axil_pkg: shared constants and FSM state types for the AXI4-Lite control register file
package ctrl_axil_pkg;
    localparam int NUM_REGS = 4;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int REG_CTRL = 0;
    localparam int REG_CFG  = 1;
    localparam int REG_ARG  = 2;
    localparam int REG_USER = 3;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/ctrl_axil_regfile.sv
// ctrl_axil_regfile: AXI4-Lite slave with four strobed 32-bit control registers and write pulses
module ctrl_axil_regfile
    import ctrl_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]                    wr_pulse_o
);
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic aw_held, w_held, aw_hs, w_hs, commit;
    logic [1:0] aw_sel_q, w_sel;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, w_data, rdata_q;
    logic [NB-1:0] wstrb_q, w_strb;
    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0] pulse_q;
    logic unused_ok;

    assign unused_ok       = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign s00_axi_awready = (w_state == W_IDLE) && !aw_held;
    assign s00_axi_wready  = (w_state == W_IDLE) && !w_held;
    assign s00_axi_bvalid  = (w_state == W_RESP);
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = (r_state == R_IDLE);
    assign s00_axi_rvalid  = (r_state == R_DATA);
    assign s00_axi_rresp   = RESP_OKAY;
    assign s00_axi_rdata   = rdata_q;
    assign regs_o          = regs;
    assign wr_pulse_o      = pulse_q;

    // Write path: commit once both AW and W are available, taking either the latched or live copy
    always_comb begin
        aw_hs  = s00_axi_awvalid && s00_axi_awready;
        w_hs   = s00_axi_wvalid && s00_axi_wready;
        commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
        w_sel  = aw_held ? aw_sel_q : s00_axi_awaddr[3:2];
        w_data = w_held ? wdata_q : s00_axi_wdata;
        w_strb = w_held ? wstrb_q : s00_axi_wstrb;
        w_next = commit ? W_RESP : (w_state == W_RESP && s00_axi_bready) ? W_IDLE : w_state;
    end

    // Read path: accept AR when idle, hold the response until rready
    always_comb begin
        r_next = (r_state == R_IDLE && s00_axi_arvalid) ? R_DATA :
                 (r_state == R_DATA && s00_axi_rready) ? R_IDLE : r_state;
    end

    // Write FSM state, independent AW/W capture and the one-cycle write pulse
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state  <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_sel_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            pulse_q  <= '0;
        end else begin
            w_state <= w_next;
            aw_held <= !commit && (aw_held || aw_hs);
            w_held  <= !commit && (w_held || w_hs);
            if (aw_hs) aw_sel_q <= s00_axi_awaddr[3:2];
            if (w_hs) begin
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
            pulse_q <= '0;
            if (commit) pulse_q[w_sel] <= 1'b1;
        end
    end

    // Register array with per-byte strobes
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            regs <= '0;
        end else if (commit) begin
            for (int b = 0; b < NB; b++)
                if (w_strb[b]) regs[w_sel][8*b +: 8] <= w_data[8*b +: 8];
        end
    end

    // Read FSM state and read data capture (same-edge writes are not yet visible here)
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && s00_axi_arvalid) rdata_q <= regs[s00_axi_araddr[3:2]];
        end
    end
endmodule

// File: tb/tb_ctrl_axil_regfile.sv
// tb_ctrl_axil_regfile: directed table-driven bench for the AXI4-Lite control register file
module tb_ctrl_axil_regfile;
    logic         clk = 1'b0;
    logic         aresetn;
    logic [3:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb, wr_pulse;
    logic [1:0]   bresp, rresp;
    logic [127:0] regs_o;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    ctrl_axil_regfile dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left just after a falling edge; AW and W are offered together
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int bstall);
        int t;
        logic [3:0] onehot;
        onehot = 4'b0001 << a[3:2];
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        t = 0;
        while (!(awready && wready) && t < 20) begin @(negedge clk); t++; end
        chk("wr_accept", {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid", bvalid, 1'b1);
        chk("bresp", bresp, 2'b00);
        chk("wr_pulse", wr_pulse, onehot);
        repeat (bstall) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1'b1);
            chk("awready_stall", awready, 1'b0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 1'b0);
        chk("awready_back", awready, 1'b1);
        chk("wr_pulse_clear", wr_pulse, 4'b0000);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input int rstall);
        int t;
        araddr = a; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 20) begin @(negedge clk); t++; end
        chk("rd_accept", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid", rvalid, 1'b1);
        chk("rresp", rresp, 2'b00);
        chk("rdata", rdata, exp);
        repeat (rstall) begin
            @(negedge clk);
            chk("rvalid_hold", rvalid, 1'b1);
            chk("rdata_hold", rdata, exp);
            chk("arready_stall", arready, 1'b0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_clear", rvalid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001},
            '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002},
            '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003},
            '{1'b1, 4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004},
            '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0001},
            '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0002},
            '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0003},
            '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0000_0004},
            '{1'b1, 4'h4, 32'h1122_3344, 4'hF, 32'h1122_3344},
            '{1'b1, 4'h6, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD},
            '{1'b0, 4'h5, 32'h0,         4'h0, 32'h11BB_33DD},
            '{1'b1, 4'h8, 32'hFFFF_FFFF, 4'h0, 32'h0000_0003}
        };
        aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        chk("rst_ready", {awready, wready, arready}, 3'b111);
        chk("rst_valid", {bvalid, rvalid}, 2'b00);
        chk("rst_resp", {bresp, rresp}, 4'b0000);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_regs", regs_o, 128'h0);
        chk("rst_pulse", wr_pulse, 4'b0000);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0);
                chk($sformatf("vec%0d_reg", i), regs_o[32*vecs[i].addr[3:2] +: 32], vecs[i].exp);
            end else begin
                do_read(vecs[i].addr, vecs[i].exp, 0);
            end
            if (i == 7) chk("regs_all", regs_o, 128'h00000004_00000003_00000002_00000001);
        end

        // W three cycles ahead of AW
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        chk("w_first_wready", wready, 1'b0);
        chk("w_first_bvalid", bvalid, 1'b0);
        chk("w_first_reg", regs_o[95:64], 32'h0000_0003);
        repeat (2) @(negedge clk);
        chk("w_first_awready", awready, 1'b1);
        awaddr = 4'h8; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("w_first_bvalid2", bvalid, 1'b1);
        chk("w_first_commit", regs_o[95:64], 32'hDEAD_BEEF);
        chk("w_first_pulse", wr_pulse, 4'b0100);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("w_first_bclear", bvalid, 1'b0);
        do_read(4'h8, 32'hDEAD_BEEF, 0);

        // Back-pressure on both response channels
        do_write(4'h0, 32'hCAFE_0001, 4'hF, 5);
        do_read(4'h0, 32'hCAFE_0001, 4);

        // Same-edge read and write of reg3
        do_write(4'hC, 32'h5, 4'hF, 0);
        awaddr = 4'hC; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'hC; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_rvalid", rvalid, 1'b1);
        chk("same_rdata_old", rdata, 32'h5);
        chk("same_bvalid", bvalid, 1'b1);
        chk("same_reg_new", regs_o[127:96], 32'h9);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        chk("same_clear", {bvalid, rvalid}, 2'b00);
        do_read(4'hC, 32'h9, 0);

        // Asynchronous reset while a write response is pending
        awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("rst_mid_bvalid", bvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("rst_mid_bvalid0", bvalid, 1'b0);
        chk("rst_mid_regs", regs_o, 128'h0);
        chk("rst_mid_ready", {awready, wready, arready}, 3'b111);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        do_write(4'h0, 32'h7, 4'hF, 0);
        chk("post_rst_regs", regs_o, 128'h7);
        do_read(4'h0, 32'h7, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_axil_regfile.md
# ctrl_axil_regfile

AXI4-Lite slave register file that terminates the control subsystem's S00_AXI port. It answers single-beat write and read transactions from the PS / AXI VIP master and exposes four 32-bit read/write control registers to the NPU control logic. Each register also drives a one-cycle write-strobe pulse. It is the responder end of the control-register path that the subsystem's BFM bench drives.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; 4 registers × 4 bytes.

Ports (one clock; reset is asynchronous and active-low, port names s00_axi_aclk / s00_axi_aresetn):
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  async active-low reset
- s00_axi_awaddr  in  4  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte-lane enables
- s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake
- s00_axi_bresp  out  2  write response
- s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake
- s00_axi_araddr  in  4  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response
- s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake
- regs_o  out  128  register contents; reg k is at bits [32k+31:32k]
- wr_pulse_o  out  4  bit k high for one cycle after reg k is written

## Operation
- Register select is addr[3:2]; addr[1:0] are ignored. All 4 offsets are valid, so BRESP and RRESP are always OKAY (2'b00).
- Write FSM states:
  - W_IDLE: awready=1 until AW is captured and wready=1 until W is captured. AW and W are latched independently and may arrive in either order or in the same cycle.
  - On the edge where both AW and W are held, go to W_RESP: commit the write, set bvalid, and set wr_pulse_o[k].
  - W_RESP: awready=wready=0 and bvalid=1 until bready; then return to W_IDLE.
- Strobed write: byte b of reg k is updated only when wstrb[b]=1. A write with wstrb=0 still gets a response and still pulses wr_pulse_o[k].
- Read FSM states:
  - R_IDLE: arready=1. On the AR handshake, latch rdata from the selected register and go to R_DATA.
  - R_DATA: arready=0 and rvalid=1, with rdata held stable, until rready; then return to R_IDLE.
- The read and write channels are fully independent and each has at most 1 outstanding transaction.

## Timing
- Reset values: all registers 0, regs_o=0, wr_pulse_o=0, bvalid=0, rvalid=0, bresp=rresp=0, rdata=0, awready=wready=arready=1 (idle-ready, registered).
- Write latency: if AW and W handshake on the same edge N, regs_o and bvalid update after edge N. If they arrive apart, the commit happens on the later handshake edge. The earliest back-to-back write AW can be accepted is the cycle after the B handshake.
- Read latency: AR handshake at edge N gives rvalid=1 with valid rdata in the following cycle. Throughput is 1 read per 2 cycles when rready is held high.
- wr_pulse_o is high for exactly the one cycle in which regs_o first shows the new value.
- Same-edge read and write to the same register: the read returns the old (pre-write) value. A read accepted in any later cycle returns the new value.
- bvalid and rvalid, once asserted, never drop without the matching ready; bresp and rdata are stable while valid.
- Reset asserted mid-transaction: immediate return to reset values, and any pending response is discarded. After reset deasserts, the first accepted transaction behaves normally.

## Structure
- Package ctrl_axil_pkg holds:
  - NUM_REGS=4
  - RESP_OKAY=2'b00
  - register index localparams REG_CTRL=0, REG_CFG=1, REG_ARG=2, REG_USER=3
  - enums for the write FSM (W_IDLE, W_RESP) and read FSM (R_IDLE, R_DATA)
- No sub-module: one module with two small FSMs and a strobed register array. Expected size is about 180 lines.

## Test plan
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then reads of the same addresses -> 0x1, 0x2, 0x3, 0x4, all responses OKAY; regs_o = 0x00000004_00000003_00000002_00000001.
- Write 0xAABBCCDD to 0x4 with wstrb=4'b0101 over a prior value of 0x11223344 -> reg1 = 0x11BB33DD; wr_pulse_o = 4'b0010 for one cycle.
- W presented 3 cycles before AW (address 0x8, data 0xDEADBEEF) -> wready drops after the W handshake, the commit happens on the AW edge, bvalid follows on the next cycle, and a readback gives 0xDEADBEEF.
- bready held low for 5 cycles after bvalid, and rready held low for 4 cycles after rvalid -> bvalid, rvalid and rdata stay stable, and no new AW or AR is accepted until each is released.
- reg3 = 0x5 with a simultaneous AR and AW+W to 0xC carrying 0x9 -> the read returns 0x5, and the next read returns 0x9.
- s00_axi_aresetn pulsed low while bvalid=1 -> bvalid=0 and regs_o=0 immediately; after release, a write/read of 0x7 to 0x0 completes normally.
